// File: rtl/mem_wb_stage.sv
// Memory-access stage and M/WB pipeline register for the five-stage MIPS core.
// Issues the single data request for the instruction in M and stalls the pipeline until dhit.
module mem_wb_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        flush,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store,
  input  logic [4:0]  ex_wsel,
  input  logic        ex_wen,
  input  logic [1:0]  ex_wdatasrc,
  input  logic [31:0] ex_pcp4,
  input  logic        ex_halt,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] wb_wdat,
  output logic [4:0]  wb_wsel,
  output logic        wb_wen,
  output logic        wb_halt
);

  // state  | meaning
  // REQ    | request driven for the M instruction (if it is a memory op)
  // DONE   | access completed, load data parked in load_buf until ihit
  // HALTED | halt retired; requests off and M/WB frozen until reset
  typedef enum logic [1:0] {
    REQ    = 2'd0,
    DONE   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] load_buf_q, load_buf_d;
  logic [31:0] wb_wdat_q, wb_wdat_d;
  logic [4:0]  wb_wsel_q, wb_wsel_d;
  logic        wb_wen_q, wb_wen_d;
  logic        wb_halt_q, wb_halt_d;

  logic        memop;
  logic        adv;
  logic [31:0] mem_data;
  logic [31:0] sel_data;

  assign memop     = ex_dREN | ex_dWEN;
  assign dmemaddr  = ex_addr;
  assign dmemstore = ex_store;

  assign wb_wdat = wb_wdat_q;
  assign wb_wsel = wb_wsel_q;
  assign wb_wen  = wb_wen_q;
  assign wb_halt = wb_halt_q;

  always_comb begin
    state_d    = state_q;
    load_buf_d = load_buf_q;
    wb_wdat_d  = wb_wdat_q;
    wb_wsel_d  = wb_wsel_q;
    wb_wen_d   = wb_wen_q;
    wb_halt_d  = wb_halt_q;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    mem_stall  = 1'b0;
    mem_data   = dmemload;
    sel_data   = ex_addr;
    adv        = 1'b0;

    case (state_q)
      REQ: begin
        // requests are gated by nRST so they drop the instant reset asserts
        dmemWEN   = ex_dWEN & nRST;
        dmemREN   = ex_dREN & ~ex_dWEN & nRST;
        mem_stall = memop & ~dhit & nRST;
        if (memop && dhit && !ihit) begin
          load_buf_d = dmemload;
          state_d    = DONE;
        end
      end
      DONE: begin
        mem_data = load_buf_q;
        if (ihit) state_d = REQ;
      end
      HALTED: ;
      default: state_d = REQ;
    endcase

    adv = ihit & ~mem_stall & (state_q != HALTED);

    case (ex_wdatasrc)
      2'd1:    sel_data = mem_data;
      2'd2:    sel_data = ex_pcp4;
      default: sel_data = ex_addr;
    endcase

    if (adv) begin
      if (flush) begin
        wb_wdat_d = '0;
        wb_wsel_d = '0;
        wb_wen_d  = 1'b0;
        wb_halt_d = 1'b0;
      end else begin
        wb_wdat_d = sel_data;
        wb_wsel_d = ex_wsel;
        wb_wen_d  = ex_wen;
        wb_halt_d = ex_halt;
        if (ex_halt) state_d = HALTED;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= REQ;
      load_buf_q <= '0;
      wb_wdat_q  <= '0;
      wb_wsel_q  <= '0;
      wb_wen_q   <= 1'b0;
      wb_halt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_buf_q <= load_buf_d;
      wb_wdat_q  <= wb_wdat_d;
      wb_wsel_q  <= wb_wsel_d;
      wb_wen_q   <= wb_wen_d;
      wb_halt_q  <= wb_halt_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the stage.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, flush;
  logic        ex_dREN, ex_dWEN;
  logic [31:0] ex_addr, ex_store, ex_pcp4, dmemload;
  logic [4:0]  ex_wsel;
  logic        ex_wen, ex_halt;
  logic [1:0]  ex_wdatasrc;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore, wb_wdat;
  logic [4:0]  wb_wsel;
  logic        wb_wen, wb_halt;

  mem_wb_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_addr(ex_addr), .ex_store(ex_store),
    .ex_wsel(ex_wsel), .ex_wen(ex_wen), .ex_wdatasrc(ex_wdatasrc), .ex_pcp4(ex_pcp4),
    .ex_halt(ex_halt), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_wdat(wb_wdat), .wb_wsel(wb_wsel), .wb_wen(wb_wen),
    .wb_halt(wb_halt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt, wen_cnt, wr_cnt;

  // model: an access that completed without ihit is "parked" with its data
  logic        m_parked, m_halted, m_adv;
  logic [31:0] m_buf, m_wdat;
  logic [4:0]  m_wsel;
  logic        m_wen, m_whalt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb();
    chk("wb_wdat", wb_wdat, m_wdat);
    chk("wb_wsel", 32'(wb_wsel), 32'(m_wsel));
    chk("wb_wen", 32'(wb_wen), 32'(m_wen));
    chk("wb_halt", 32'(wb_halt), 32'(m_whalt));
  endtask

  task automatic model_reset();
    m_parked = 0; m_halted = 0; m_buf = 0; m_adv = 1;
    m_wdat = 0; m_wsel = 0; m_wen = 0; m_whalt = 0;
  endtask

  task automatic set_idle();
    ihit = 0; dhit = 0; flush = 0; ex_dREN = 0; ex_dWEN = 0;
    ex_addr = 0; ex_store = 0; ex_pcp4 = 0; ex_wsel = 0; ex_wen = 0;
    ex_wdatasrc = 0; ex_halt = 0; dmemload = 0;
  endtask

  // one clock: check request side at negedge, advance model at posedge, check M/WB after
  task automatic cycle();
    logic active, memop, e_stall, adv;
    logic [31:0] mdata, wdat;
    @(negedge CLK);
    memop   = ex_dREN | ex_dWEN;
    active  = !m_halted && !m_parked;
    e_stall = active && memop && !dhit;
    chk("dmemWEN", 32'(dmemWEN), 32'(active && ex_dWEN));
    chk("dmemREN", 32'(dmemREN), 32'(active && ex_dREN && !ex_dWEN));
    chk("mem_stall", 32'(mem_stall), 32'(e_stall));
    chk("dmemaddr", dmemaddr, ex_addr);
    chk("dmemstore", dmemstore, ex_store);
    if (mem_stall) stall_cnt++;
    if (dmemWEN) wen_cnt++;
    if (dmemWEN && dhit) wr_cnt++;
    adv   = ihit && !e_stall && !m_halted;
    mdata = m_parked ? m_buf : dmemload;
    wdat  = (ex_wdatasrc == 2'd1) ? mdata : (ex_wdatasrc == 2'd2) ? ex_pcp4 : ex_addr;
    @(posedge CLK);
    if (adv) begin
      m_parked = 0;
      if (flush) begin
        m_wdat = 0; m_wsel = 0; m_wen = 0; m_whalt = 0;
      end else begin
        m_wdat = wdat; m_wsel = ex_wsel; m_wen = ex_wen; m_whalt = ex_halt;
        if (ex_halt) m_halted = 1;
      end
    end else if (active && memop && dhit) begin
      m_parked = 1;
      m_buf    = dmemload;
    end
    m_adv = adv;
    #1;
    chk_wb();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    model_reset();
    chk("rst_dmemREN", 32'(dmemREN), 32'd0);
    chk("rst_dmemWEN", 32'(dmemWEN), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk_wb();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    int hcnt;
    nRST = 1'b0;
    set_idle();
    ex_dREN = 1; ex_addr = 32'h100;
    stall_cnt = 0; wen_cnt = 0; wr_cnt = 0;
    model_reset();
    #1;
    chk("init_dmemREN", 32'(dmemREN), 32'd0);
    chk_wb();
    @(posedge CLK); #1; nRST = 1'b1;

    // load in flight, then reset mid-access
    cycle();
    chk("pre_rst_stall", 32'(stall_cnt), 32'd1);
    do_reset();

    // ALU op
    set_idle();
    ex_addr = 32'h10; ex_wsel = 5; ex_wen = 1; ihit = 1;
    stall_cnt = 0;
    cycle();
    chk("alu_wdat", wb_wdat, 32'h10);
    chk("alu_wsel", 32'(wb_wsel), 32'd5);
    chk("alu_stall", 32'(stall_cnt), 32'd0);

    // load, dhit three cycles later together with ihit
    set_idle();
    ex_dREN = 1; ex_addr = 32'h100; ex_wdatasrc = 1; ex_wsel = 7; ex_wen = 1; ihit = 1;
    stall_cnt = 0;
    repeat (3) cycle();
    dhit = 1; dmemload = 32'hDEADBEEF;
    cycle();
    chk("ld_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("ld_wdat", wb_wdat, 32'hDEADBEEF);

    // store: dhit in cycle 2, ihit in cycle 5; dhit in cycle 3 must be ignored
    set_idle();
    ex_dWEN = 1; ex_addr = 32'h200; ex_store = 32'hCAFE0001; ex_wsel = 9;
    wen_cnt = 0; wr_cnt = 0;
    cycle();
    dhit = 1; cycle();
    dmemload = 32'h12345678; cycle();
    dhit = 0; cycle();
    chk("st_wb_held", 32'(wb_wsel), 32'd7);
    ihit = 1; cycle();
    chk("st_wen_cycles", 32'(wen_cnt), 32'd2);
    chk("st_writes", 32'(wr_cnt), 32'd1);
    chk("st_wb_wsel", 32'(wb_wsel), 32'd9);

    // JAL flushed, then not flushed
    set_idle();
    ex_wdatasrc = 2; ex_pcp4 = 32'h44; ex_wsel = 31; ex_wen = 1; flush = 1; ihit = 1;
    cycle();
    chk("jal_fl_wdat", wb_wdat, 32'h0);
    chk("jal_fl_wen", 32'(wb_wen), 32'd0);
    flush = 0;
    cycle();
    chk("jal_wdat", wb_wdat, 32'h44);
    chk("jal_wsel", 32'(wb_wsel), 32'd31);

    // halt, then loads with hits must do nothing
    set_idle();
    ex_halt = 1; ihit = 1;
    cycle();
    chk("halt_set", 32'(wb_halt), 32'd1);
    set_idle();
    ex_dREN = 1; ex_addr = 32'h300; ex_wdatasrc = 1; ex_wsel = 4; ex_wen = 1;
    ihit = 1; dhit = 1; dmemload = 32'h55AA55AA;
    repeat (4) cycle();
    chk("halt_sticky", 32'(wb_halt), 32'd1);
    chk("halt_wsel", 32'(wb_wsel), 32'd0);
    do_reset();

    // random traffic; ex_* only changes after an advance
    hcnt = 0;
    set_idle();
    for (int i = 0; i < 600; i++) begin
      if (m_adv) begin
        logic [3:0] kind;
        kind        = 4'($urandom_range(0, 15));
        ex_dREN     = (kind < 5) || (kind == 12);
        ex_dWEN     = (kind >= 5 && kind < 8) || (kind == 12);
        ex_addr     = $urandom;
        ex_store    = $urandom;
        ex_pcp4     = $urandom;
        ex_wsel     = 5'($urandom);
        ex_wen      = 1'($urandom);
        ex_wdatasrc = 2'($urandom);
        ex_halt     = ($urandom_range(0, 29) == 0);
      end
      ihit     = ($urandom_range(0, 9) < 6);
      dhit     = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 9) < 2);
      dmemload = $urandom;
      cycle();
      if (m_halted) hcnt++;
      if (hcnt > 4) begin
        hcnt = 0;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus M/WB pipeline register for the five-stage pipelined MIPS core. It consumes the EX/M latch outputs and issues the single data-memory request for the instruction in M. It holds the pipeline with `mem_stall` until `dhit`, buffers load data if fetch has not yet hit, and registers the selected writeback value, destination and halt flag for the WB stage.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits and register selects are 5 bits.

Ports:
- `CLK`  in  1  clock; all state is rising-edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ihit`  in  1  instruction fetch hit; the pipeline may advance.
- `dhit`  in  1  data-memory access completes this cycle.
- `flush`  in  1  insert a bubble into M/WB on the next advance.
- `ex_dREN`, `ex_dWEN`  in  1 each  load/store from EX/M.
- `ex_addr`  in  32  ALU result (`portO`): memory address or ALU writeback value.
- `ex_store`  in  32  store data.
- `ex_wsel`  in  5  destination register.
- `ex_wen`  in  1  register write enable.
- `ex_wdatasrc`  in  2  writeback source: 0 = ALU, 1 = memory, 2 = pcp4, 3 = ALU.
- `ex_pcp4`  in  32  PC+4.
- `ex_halt`  in  1  halt instruction.
- `dmemload`  in  32  load data, valid with `dhit`.
- `dmemREN`, `dmemWEN`  out  1 each  data-memory request.
- `dmemaddr`, `dmemstore`  out  32 each  request address and data.
- `mem_stall`  out  1  freeze all upstream latches and the PC.
- `wb_wdat`  out  32  registered writeback data.
- `wb_wsel`  out  5  registered destination.
- `wb_wen`  out  1  registered write enable.
- `wb_halt`  out  1  registered halt; sticky.

## Operation
- States: REQ (reset state), DONE, HALTED.
- `memop = ex_dREN | ex_dWEN`. `dmemaddr = ex_addr`, `dmemstore = ex_store` (combinational).
- REQ:
  - `dmemWEN = ex_dWEN`; `dmemREN = ex_dREN & ~ex_dWEN`. dWEN has priority when both are set.
  - `mem_stall = memop & ~dhit`.
- DONE:
  - Requests deasserted; `mem_stall = 0`.
  - Memory data comes from `load_buf`.
- HALTED:
  - Requests deasserted; `mem_stall = 0`.
  - M/WB frozen.
- `adv = ihit & ~mem_stall & (state != HALTED)`.
- Memory data source: `dmemload` in REQ, `load_buf` in DONE.
- Writeback data source by `ex_wdatasrc`: 0 = `ex_addr`, 1 = memory data, 2 = `ex_pcp4`, 3 = `ex_addr`.
- Transitions:
  - REQ, `memop & dhit & ~ihit`: `load_buf <= dmemload`, go to DONE. The access is complete and is never reissued.
  - REQ, `memop & dhit & ihit`: M/WB captures `dmemload` directly; stay in REQ.
  - DONE, `ihit`: M/WB captures from `load_buf`; go to REQ.
  - Any state with `adv & ~flush & ex_halt`: go to HALTED. Only `nRST` leaves HALTED.
- M/WB register on `adv`:
  - `flush = 1`: `wb_wdat`, `wb_wsel`, `wb_wen` and `wb_halt` all load 0.
  - Otherwise: load the selected data, `ex_wsel`, `ex_wen` and `ex_halt`.
  - Without `adv` the register holds.
- `flush` never cancels an issued or completed memory access. It only affects what M/WB captures.
- `dhit` with no request outstanding (not REQ, or `~memop`) is ignored.
- Upstream (EX/M, ID/EX, IF/ID, PC) advances on exactly `adv`, so `ex_*` inputs are stable across the stall.

## Timing
- Reset, asynchronous on `nRST` low:
  - Outputs: `wb_wdat = 0`, `wb_wsel = 0`, `wb_wen = 0`, `wb_halt = 0`.
  - State: REQ; `load_buf = 0`.
  - `dmemREN`/`dmemWEN` drop in the same cycle, even mid-access.
- Non-memory instruction: one-cycle latency. M/WB updates on the first edge with `ihit`.
- Memory op, `dhit` in cycle N with `ihit`: M/WB updated at the end of N.
  - `mem_stall` is high in cycles before N and low in N.
- Memory op, `dhit` in cycle N, first `ihit` in cycle M > N:
  - Request asserted through cycle N only; DONE from N+1 to M.
  - M/WB updated at the end of M.
- Request outputs are combinational from state and `ex_*`, with no cycle of delay after an advance.

## Test plan
- Reset mid-load (`ex_dREN = 1`, no `dhit`) -> `dmemREN` drops immediately, `wb_* = 0`, state REQ.
- ALU op, `ex_addr = 0x0000_0010`, `wdatasrc = 0`, `wsel = 5`, `wen = 1`, `ihit` -> next cycle `wb_wdat = 0x10`, `wb_wsel = 5`, `wb_wen = 1`; `mem_stall` never high.
- Load at `0x100`, `dhit` 3 cycles later together with `ihit`, `dmemload = 0xDEADBEEF`:
  - `mem_stall` high for 3 cycles.
  - `dmemREN` held and `dmemaddr = 0x100` throughout.
  - Then `wb_wdat = 0xDEADBEEF`.
- Store, `dhit` in cycle 2, `ihit` in cycle 5:
  - `dmemWEN` high in cycles 1-2 only, then low in DONE.
  - M/WB updates after cycle 5.
  - Exactly one write is issued.
- JAL with `wdatasrc = 2`, `ex_pcp4 = 0x44`, `wsel = 31` and `flush = 1` -> M/WB is all zero. Repeat without flush -> `wb_wdat = 0x44`, `wb_wsel = 31`.
- HALT advanced -> `wb_halt = 1` and stays 1. Later loads with `dhit`/`ihit` cause no request and no M/WB change until reset.
